me_engine: RTL and testbench

Full-search block-matching motion-estimation engine. It holds one 16x16 current macroblock and one 32x32 reference search window, both 8-bit luma, in internal word-addressed RAMs loaded over two 64-bit write ports. On `go` it computes the sum of absolute differences (SAD) at every candidate position, selected by search range `r`. It then reports the best-match position as (`m_i`, `m_j`) with a one-cycle `done` pulse. It sits between the frame-buffer loader and the motion-vector writer of the encoder.

---
 rtl/me_engine.sv | 187 ++++++++++++++++++
 tb/tb_me_engine.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/me_engine.sv
// me_engine: full-search 16x16 block-matching motion estimator over a 32x32
// reference window. One block row (16 absolute differences) is accumulated per
// cycle; the RAM fetch runs one cycle ahead of the accumulation, so a search
// of N candidates takes 16N+1 cycles in CALC.
//
// Handshake: go is a single-cycle request honoured only in IDLE (r is sampled
// with it); done is a single-cycle result-valid pulse with m_i/m_j valid in the
// same cycle and held until the next done. There is no back-pressure.
module me_engine (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_write,
  input  logic        clk_read,
  input  logic [1:0]  r,
  input  logic        go,
  input  logic [6:0]  address_write_ref,
  input  logic [63:0] data_write_ref,
  input  logic        write_enable_ref,
  input  logic [4:0]  address_write_cur,
  input  logic [63:0] data_write_cur,
  input  logic        write_enable_cur,
  output logic [7:0]  m_i,
  output logic [7:0]  m_j,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_next;

  logic [63:0]  ref_ram [128];
  logic [63:0]  cur_ram [32];

  // search bounds and fetch-side candidate/row counters
  logic [4:0]   lo, hi;
  logic [4:0]   fi, fj;
  logic [3:0]   fy;
  logic         fetch_on;
  logic [4:0]   ref_row_addr;
  logic [4:0]   radius;

  // accumulate-side pipeline registers
  logic         p_valid;
  logic         p_last;
  logic [4:0]   p_i, p_j;
  logic [3:0]   p_y;
  logic [255:0] ref_words;
  logic [127:0] cur_words;

  logic [15:0]  acc;
  logic [15:0]  best_sad;
  logic [4:0]   best_i, best_j;
  logic         have_best;

  logic [255:0] ref_shifted;
  logic [127:0] ref_seg;
  logic [11:0]  row_sad;
  logic [15:0]  cand_sad;
  logic         better;
  logic         row_end;

  // the two compatibility clocks are tied to clk and carry no function
  logic         unused_clks;
  assign unused_clks = clk_write ^ clk_read;

  assign radius       = 5'd8 >> r;
  assign ref_row_addr = fi + {1'b0, fy};
  assign row_end      = p_valid && (p_y == 4'd15);
  assign done         = (state == DONE);

  // RAM writes: any state, no reset on contents
  always_ff @(posedge clk) begin
    if (write_enable_ref) ref_ram[address_write_ref] <= data_write_ref;
    if (write_enable_cur) cur_ram[address_write_cur] <= data_write_cur;
  end

  // row SAD of the fetched row, and the running candidate SAD / best test
  always_comb begin
    ref_shifted = ref_words >> {p_j, 3'b000};
    ref_seg     = ref_shifted[127:0];
    row_sad     = 12'd0;
    for (int k = 0; k < 16; k++) begin
      if (cur_words[8*k +: 8] > ref_seg[8*k +: 8])
        row_sad = row_sad + {4'd0, cur_words[8*k +: 8] - ref_seg[8*k +: 8]};
      else
        row_sad = row_sad + {4'd0, ref_seg[8*k +: 8] - cur_words[8*k +: 8]};
    end
    cand_sad = acc + {4'd0, row_sad};
    better   = !have_best || (cand_sad < best_sad);
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state: leave CALC once the last row of the last candidate is summed
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = CALC;
      CALC:    if (row_end && p_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // datapath: row fetch, accumulation, best tracking and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo        <= 5'd0;
      hi        <= 5'd0;
      fi        <= 5'd0;
      fj        <= 5'd0;
      fy        <= 4'd0;
      fetch_on  <= 1'b0;
      p_valid   <= 1'b0;
      p_last    <= 1'b0;
      p_i       <= 5'd0;
      p_j       <= 5'd0;
      p_y       <= 4'd0;
      ref_words <= '0;
      cur_words <= '0;
      acc       <= 16'd0;
      best_sad  <= 16'd0;
      best_i    <= 5'd0;
      best_j    <= 5'd0;
      have_best <= 1'b0;
      m_i       <= 8'd0;
      m_j       <= 8'd0;
    end else if (state == IDLE) begin
      if (go) begin
        lo        <= 5'd8 - radius;
        hi        <= 5'd8 + radius;
        fi        <= 5'd8 - radius;
        fj        <= 5'd8 - radius;
        fy        <= 4'd0;
        fetch_on  <= 1'b1;
        p_valid   <= 1'b0;
        acc       <= 16'd0;
        have_best <= 1'b0;
      end
    end else if (state == CALC) begin
      p_valid <= fetch_on;
      if (fetch_on) begin
        ref_words <= {ref_ram[{ref_row_addr, 2'd3}], ref_ram[{ref_row_addr, 2'd2}],
                      ref_ram[{ref_row_addr, 2'd1}], ref_ram[{ref_row_addr, 2'd0}]};
        cur_words <= {cur_ram[{fy, 1'b1}], cur_ram[{fy, 1'b0}]};
        p_i       <= fi;
        p_j       <= fj;
        p_y       <= fy;
        p_last    <= (fy == 4'd15) && (fj == hi) && (fi == hi);
        if (fy == 4'd15) begin
          fy <= 4'd0;
          if (fj == hi) begin
            fj <= lo;
            if (fi == hi) fetch_on <= 1'b0;
            else          fi <= fi + 5'd1;
          end else begin
            fj <= fj + 5'd1;
          end
        end else begin
          fy <= fy + 4'd1;
        end
      end
      if (p_valid) begin
        if (p_y == 4'd15) begin
          acc       <= 16'd0;
          have_best <= 1'b1;
          if (better) begin
            best_sad <= cand_sad;
            best_i   <= p_i;
            best_j   <= p_j;
          end
          if (p_last) begin
            m_i <= {3'd0, better ? p_i : best_i};
            m_j <= {3'd0, better ? p_j : best_j};
          end
        end else begin
          acc <= cand_sad;
        end
      end
    end
  end

endmodule

// File: tb/tb_me_engine.sv
// Bench for me_engine: directed searches with known best offsets; a monitor
// pops the expected {done cycle, m_i, m_j} whenever done is seen.
module tb_me_engine;

  logic        clk;
  logic        reset;
  logic [1:0]  r;
  logic        go;
  logic [6:0]  address_write_ref;
  logic [63:0] data_write_ref;
  logic        write_enable_ref;
  logic [4:0]  address_write_cur;
  logic [63:0] data_write_cur;
  logic        write_enable_cur;
  logic [7:0]  m_i, m_j;
  logic        done;

  me_engine dut (
    .clk               (clk),
    .reset             (reset),
    .clk_write         (clk),
    .clk_read          (clk),
    .r                 (r),
    .go                (go),
    .address_write_ref (address_write_ref),
    .data_write_ref    (data_write_ref),
    .write_enable_ref  (write_enable_ref),
    .address_write_cur (address_write_cur),
    .data_write_cur    (data_write_cur),
    .write_enable_cur  (write_enable_cur),
    .m_i               (m_i),
    .m_j               (m_j),
    .done              (done)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model data ----------------
  logic [7:0]  ref_img [32][32];
  logic [7:0]  cur_img [16][16];
  logic [31:0] rng;

  // expected entry: {done cycle[47:16], m_i[15:8], m_j[7:0]}
  logic [47:0] exp_q [$];
  logic [15:0] held_exp = 16'h0000;
  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [47:0] e;
    if (!reset) begin
      checks++;
      if (done !== 1'b0 || m_i !== 8'd0 || m_j !== 8'd0) begin
        errors++;
        $display("FAIL reset_outputs: done=%b m_i=%0d m_j=%0d, required 0 0 0", done, m_i, m_j);
      end
      held_exp = 16'h0000;
    end else if (done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: at cycle %0d m_i=%0d m_j=%0d, no result was expected", cyc, m_i, m_j);
      end else begin
        e = exp_q.pop_front();
        if (cyc != int'(e[47:16]) || {m_i, m_j} !== e[15:0]) begin
          errors++;
          $display("FAIL result: cycle=%0d m_i=%0d m_j=%0d, required cycle=%0d m_i=%0d m_j=%0d",
                   cyc, m_i, m_j, e[47:16], e[15:8], e[7:0]);
        end
        held_exp = e[15:0];
      end
    end else begin
      checks++;
      if (exp_q.size() > 0 && cyc > int'(exp_q[0][47:16])) begin
        e = exp_q.pop_front();
        errors++;
        $display("FAIL done_timeout: no done by cycle %0d, required at cycle %0d (m_i=%0d m_j=%0d)",
                 cyc, e[47:16], e[15:8], e[7:0]);
      end else if ({m_i, m_j} !== held_exp || done !== 1'b0) begin
        errors++;
        $display("FAIL hold: done=%b m_i=%0d m_j=%0d, required done=0 m_i=%0d m_j=%0d",
                 done, m_i, m_j, held_exp[15:8], held_exp[7:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_window(input logic [31:0] seed);
    rng = seed;
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++) begin
        rng = rng * 32'd1103515245 + 32'd12345;
        ref_img[y][x] = rng[23:16];
      end
  endtask

  task automatic fill_zero();
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++) ref_img[y][x] = 8'd0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) cur_img[y][x] = 8'd0;
  endtask

  task automatic copy_cur(input int oi, input int oj);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) cur_img[y][x] = ref_img[oi + y][oj + x];
  endtask

  // one word of each RAM per cycle, both ports in parallel
  task automatic load_rams();
    for (int a = 0; a < 128; a++) begin
      @(negedge clk);
      address_write_ref = a[6:0];
      for (int k = 0; k < 8; k++)
        data_write_ref[8*k +: 8] = ref_img[a >> 2][(a & 3) * 8 + k];
      write_enable_ref = 1'b1;
      if (a < 32) begin
        address_write_cur = a[4:0];
        for (int k = 0; k < 8; k++)
          data_write_cur[8*k +: 8] = cur_img[a >> 1][(a & 1) * 8 + k];
        write_enable_cur = 1'b1;
      end else begin
        write_enable_cur = 1'b0;
      end
    end
    @(negedge clk);
    write_enable_ref = 1'b0;
    write_enable_cur = 1'b0;
  endtask

  // go sampled at the next posedge (cycle g); done expected at cycle g+16N+1
  task automatic start(input logic [1:0] rr, input int ei, input int ej, input bit expect_it);
    int rad, n;
    @(negedge clk);
    rad = 8 >> rr;
    n   = (2 * rad + 1) * (2 * rad + 1);
    r   = rr;
    go  = 1'b1;
    if (expect_it)
      exp_q.push_back({32'(cyc + 2 + 16 * n), 8'(ei), 8'(ej)});
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (done === 1'b1) break;
      n++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    r = 2'd0;
    go = 1'b0;
    address_write_ref = '0;
    data_write_ref = '0;
    write_enable_ref = 1'b0;
    address_write_cur = '0;
    data_write_cur = '0;
    write_enable_cur = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // exact copy at (5,11), full range, with a stray go mid-search
    fill_window(32'h1234_5678);
    copy_cur(5, 11);
    load_rams();
    start(2'd0, 5, 11, 1'b1);
    repeat (2000) @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_done(4700);

    // copy at (8,9): smallest range, then r=2 with go right after done
    copy_cur(8, 9);
    load_rams();
    start(2'd3, 8, 9, 1'b1);
    wait_done(200);
    start(2'd2, 8, 9, 1'b1);
    wait_done(450);

    // reset 100 cycles into a search: no done, outputs cleared, RAMs kept
    start(2'd0, 0, 0, 1'b0);
    repeat (100) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4700) @(negedge clk);
    start(2'd3, 8, 9, 1'b1);
    wait_done(200);

    // all-zero data: every SAD ties, the first candidate wins
    fill_zero();
    load_rams();
    start(2'd0, 0, 0, 1'b1);
    wait_done(4700);
    start(2'd1, 4, 4, 1'b1);
    wait_done(1400);

    // back-to-back pairs, reload starts on the cycle after done
    fill_window(32'h0bad_cafe);
    copy_cur(9, 7);
    load_rams();
    start(2'd2, 9, 7, 1'b1);
    wait_done(450);
    fill_window(32'h7777_1111);
    copy_cur(7, 8);
    load_rams();
    start(2'd3, 7, 8, 1'b1);
    wait_done(200);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
